regfile_wr_arbiter: RTL and testbench

- Shares the NUM_PORTS write ports of a multiported register file (e.g. a 4-write / 6-read 128-entry regfile) among NUM_REQ independent write requesters.
- Each cycle it grants up to NUM_PORTS requests in round-robin order and suppresses same-address collisions within a cycle.
- Granted writes are driven onto registered write-port outputs that connect directly to the regfile Wn_en/Wn_addr/Wn_data pins.

---
 rtl/regfile_wr_arbiter_if.sv | 27 ++
 rtl/regfile_wr_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - requester and regfile write-port bundle for regfile_wr_arbiter
interface regfile_wr_arbiter_if #(
    parameter int NUM_REQ   = 6,
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 9,
    parameter int STALL_W   = 16
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_PORTS-1:0]        w_en;
    logic [NUM_PORTS*ADDR_W-1:0] w_addr;
    logic [NUM_PORTS*DATA_W-1:0] w_data;
    logic [STALL_W-1:0]          stall_cnt;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, w_en, w_addr, w_data, stall_cnt
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, w_en, w_addr, w_data, stall_cnt
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin sharing of regfile write ports among write requesters
module regfile_wr_arbiter #(
    parameter int NUM_REQ   = 6,
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 9,
    parameter int STALL_W   = 16
) (
    input logic                  clock,
    input logic                  reset,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t                        rr_q, rr_d;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_PORTS-1:0]        w_en_d, w_en_q;
    logic [ADDR_W-1:0]           slot_addr [NUM_PORTS];
    logic [DATA_W-1:0]           slot_data [NUM_PORTS];
    logic [NUM_PORTS*ADDR_W-1:0] w_addr_q;
    logic [NUM_PORTS*DATA_W-1:0] w_data_q;
    logic [STALL_W-1:0]          stall_q, stall_d;

    // Walk requesters from rr_q; the k-th grant lands in slot k, and a slot's
    // address blocks any later requester with the same address this cycle.
    always_comb begin : scan
        int          cnt;
        int          idx;
        int          last;
        logic        coll;
        logic        cur_v;
        logic [ADDR_W-1:0] cur_a;
        logic [DATA_W-1:0] cur_d;
        grant  = '0;
        w_en_d = '0;
        rr_d   = rr_q;
        cnt    = 0;
        idx    = 0;
        last   = 0;
        coll   = 1'b0;
        cur_v  = 1'b0;
        cur_a  = '0;
        cur_d  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            slot_addr[p] = '0;
            slot_data[p] = '0;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = int'(rr_q) + j;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cur_v = 1'b0;
            cur_a = '0;
            cur_d = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == idx) begin
                    cur_v = bus.req_valid[i];
                    cur_a = bus.req_addr[i*ADDR_W +: ADDR_W];
                    cur_d = bus.req_data[i*DATA_W +: DATA_W];
                end
            end
            coll = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (p < cnt && slot_addr[p] == cur_a) coll = 1'b1;
            end
            if (!reset && cur_v && cnt < NUM_PORTS && !coll) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == idx) grant[i] = 1'b1;
                end
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (p == cnt) begin
                        slot_addr[p] = cur_a;
                        slot_data[p] = cur_d;
                        w_en_d[p]    = 1'b1;
                    end
                end
                cnt  = cnt + 1;
                last = idx;
            end
        end
        if (cnt != 0) rr_d = (last == NUM_REQ - 1) ? '0 : ptr_t'(last + 1);
    end

    always_comb begin
        stall_d = stall_q;
        if ((bus.req_valid & ~grant) != '0 && stall_q != '1) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_en_q   <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
            rr_q     <= '0;
            stall_q  <= '0;
        end else begin
            w_en_q <= w_en_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_en_d[p]) begin
                    w_addr_q[p*ADDR_W +: ADDR_W] <= slot_addr[p];
                    w_data_q[p*DATA_W +: DATA_W] <= slot_data[p];
                end
            end
            rr_q    <= rr_d;
            stall_q <= stall_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.w_en      = w_en_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.w_data    = w_data_q;
    assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - randomized and directed checks of regfile_wr_arbiter against a reference model
module tb_regfile_wr_arbiter;
    localparam int NR = 6;
    localparam int NP = 4;
    localparam int AW = 7;
    localparam int DW = 9;
    localparam int SW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    regfile_wr_arbiter_if #(.NUM_REQ(NR), .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .STALL_W(SW)) bus ();

    regfile_wr_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .STALL_W(SW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [AW-1:0]    a [NR];
    logic [DW-1:0]    d [NR];
    logic [NR-1:0]    pend;
    logic [NR-1:0]    last_g;
    logic [NP-1:0]    exp_en;
    logic [NP*AW-1:0] exp_addr;
    logic [NP*DW-1:0] exp_data;
    int               rr;
    int               stall;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check ready mid-cycle, advance the model, check registered outputs.
    task automatic step(input logic rst_v, input logic [NR-1:0] vv);
        int            order[$];
        logic [AW-1:0] used[$];
        logic [NR-1:0] g;
        bit            hit;
        reset = rst_v;
        bus.req_valid = vv;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*AW +: AW] = a[i];
            bus.req_data[i*DW +: DW] = d[i];
        end
        #3;
        g = '0;
        if (!rst_v) begin
            for (int j = 0; j < NR; j++) begin
                int i;
                i = (rr + j) % NR;
                if (vv[i] && order.size() < NP) begin
                    hit = 0;
                    foreach (used[u]) if (used[u] == a[i]) hit = 1;
                    if (!hit) begin
                        g[i] = 1'b1;
                        order.push_back(i);
                        used.push_back(a[i]);
                    end
                end
            end
        end
        chk("req_ready", bus.req_ready, g);
        chk("w_en_mid", bus.w_en, exp_en);
        if (rst_v) begin
            exp_en = '0; exp_addr = '0; exp_data = '0; rr = 0; stall = 0;
        end else begin
            exp_en = '0;
            foreach (order[k]) begin
                exp_en[k] = 1'b1;
                exp_addr[k*AW +: AW] = a[order[k]];
                exp_data[k*DW +: DW] = d[order[k]];
            end
            if (order.size() > 0) rr = (order[order.size()-1] + 1) % NR;
            if ((vv & ~g) != '0 && stall < (1 << SW) - 1) stall++;
        end
        @(posedge clock);
        #1;
        chk("w_en", bus.w_en, exp_en);
        chk("w_addr", bus.w_addr, exp_addr);
        chk("w_data", bus.w_data, exp_data);
        chk("stall_cnt", bus.stall_cnt, stall);
        last_g = g;
    endtask

    task automatic set_distinct();
        for (int i = 0; i < NR; i++) begin
            a[i] = AW'(i);
            d[i] = DW'($urandom);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        pend = '0; last_g = '0;
        exp_en = '0; exp_addr = '0; exp_data = '0; rr = 0; stall = 0;
        set_distinct();
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_w_en", bus.w_en, 0);
        chk("rst_w_addr", bus.w_addr, 0);
        chk("rst_w_data", bus.w_data, 0);
        chk("rst_stall", bus.stall_cnt, 0);
        chk("rst_ready", bus.req_ready, 0);

        // two requesters, distinct addresses
        a[0] = 7'd3; a[2] = 7'd9; d[0] = 9'h1a5; d[2] = 9'h04c;
        step(0, 6'b000101);
        chk("t1_grant", last_g, 6'b000101);
        chk("t1_w_en", bus.w_en, 4'b0011);
        chk("t1_addr", bus.w_addr[13:0], {7'd9, 7'd3});
        chk("t1_data", bus.w_data[17:0], {9'h04c, 9'h1a5});
        step(0, 6'b000000);
        chk("empty_w_en", bus.w_en, 0);

        // full: six valid, four ports
        step(1, 6'b000000);
        set_distinct();
        step(0, 6'b111111);
        chk("t2_stall", bus.stall_cnt, 1);
        chk("t2_w_en", bus.w_en, 4'b1111);
        step(0, 6'b110000);
        chk("t2b_w_en", bus.w_en, 4'b0011);
        chk("t2b_addr", bus.w_addr[13:0], {7'd5, 7'd4});
        chk("t2b_stall", bus.stall_cnt, 1);

        // same-address collision
        step(1, 6'b000000);
        a[1] = 7'd17; a[3] = 7'd17;
        step(0, 6'b001010);
        chk("t3_stall", bus.stall_cnt, 1);
        chk("t3_w_en", bus.w_en, 4'b0001);
        step(0, 6'b001000);
        chk("t3b_w_en", bus.w_en, 4'b0001);
        chk("t3b_addr", bus.w_addr[6:0], 7'd17);

        // pointer wrap-around
        step(1, 6'b000000);
        set_distinct();
        step(0, 6'b010000);
        step(0, 6'b100001);
        chk("t4_w_en", bus.w_en, 4'b0011);
        chk("t4_addr", bus.w_addr[13:0], {7'd0, 7'd5});
        step(0, 6'b000011);
        chk("t4b_addr", bus.w_addr[13:0], {7'd0, 7'd1});

        // reset right after a two-grant acceptance
        step(1, 6'b000000);
        step(0, 6'b000101);
        step(1, 6'b111111);
        chk("t6_w_en", bus.w_en, 0);
        step(1, 6'b111111);
        step(0, 6'b000000);
        chk("t6_stall", bus.stall_cnt, 0);

        // randomized traffic with held requests and occasional reset
        step(1, 6'b000000);
        pend = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i]) begin
                    pend[i] = ($urandom_range(0, 2) != 0);
                    a[i]    = AW'($urandom_range(0, 7));
                    d[i]    = DW'($urandom);
                end
            end
            step(($urandom_range(0, 49) == 0), pend);
            pend = pend & ~last_g;
        end

        // saturation of the stall counter
        step(1, 6'b000000);
        set_distinct();
        for (int n = 0; n < 20; n++) step(0, 6'b111111);
        chk("sat_stall", bus.stall_cnt, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
